// File: rtl/ysyx_22050039_mem_arbiter.sv
// ysyx_22050039_mem_arbiter
// Shares the single physical memory port between instruction fetch (IF) and
// load/store (LS). One outstanding transaction, round-robin on ties, and a
// response timeout so that every accepted request is answered exactly once.
module ysyx_22050039_mem_arbiter #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
    input  logic            clk,
    input  logic            rst,
    // instruction fetch port
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_rsp_valid,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_rsp_err,
    // load/store port
    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic [XLEN-1:0] ls_addr,
    input  logic            ls_wen,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [7:0]      ls_wmask,
    output logic            ls_rsp_valid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_rsp_err,
    // memory port
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_wen,
    output logic [7:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;   // 1 = LS was granted most recently
    logic             owner_ls;     // owner of the transaction in flight
    logic             grant_if;
    logic             grant_ls;
    logic             busy;
    logic             done_ok;
    logic             done_to;

    // Arbitration: sole requester wins; on a tie the side not granted last wins.
    // Gated by rst so no handshake is offered while reset is asserted.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (rst && (state == S_IDLE)) begin
            if (if_req_valid && ls_req_valid) begin
                grant_if = last_grant;
                grant_ls = !last_grant;
            end else begin
                grant_if = if_req_valid;
                grant_ls = ls_req_valid;
            end
        end
    end

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign mem_req_valid = (state == S_REQ);

    assign busy    = (state == S_REQ) || (state == S_RESP);
    assign done_ok = (state == S_RESP) && mem_rsp_valid;
    // A real response in the last allowed cycle takes priority over the timeout.
    assign done_to = busy && !done_ok && (cnt == CNT_W'(TIMEOUT - 1));

    // Transaction FSM, timeout counter and latched request fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_grant <= 1'b0;
            owner_ls   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wen    <= 1'b0;
            mem_wmask  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_if || grant_ls) begin
                        state      <= S_REQ;
                        cnt        <= '0;
                        owner_ls   <= grant_ls;
                        last_grant <= grant_ls;
                        mem_addr   <= grant_ls ? ls_addr : if_addr;
                        mem_wdata  <= grant_ls ? ls_wdata : '0;
                        mem_wen    <= grant_ls && ls_wen;
                        mem_wmask  <= grant_ls ? ls_wmask : '0;
                    end
                end
                S_REQ, S_RESP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (done_ok || done_to) begin
                        state <= S_IDLE;
                    end else if ((state == S_REQ) && mem_req_ready) begin
                        state <= S_RESP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Response pulses to the owner; data and error hold between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rsp_valid <= 1'b0;
            if_rdata     <= '0;
            if_rsp_err   <= 1'b0;
            ls_rsp_valid <= 1'b0;
            ls_rdata     <= '0;
            ls_rsp_err   <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            if (done_ok || done_to) begin
                if (owner_ls) begin
                    ls_rsp_valid <= 1'b1;
                    ls_rsp_err   <= done_to;
                    ls_rdata     <= (done_to || mem_wen) ? '0 : mem_rdata;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_err   <= done_to;
                    if_rdata     <= done_to ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050039_mem_arbiter.sv
// tb_ysyx_22050039_mem_arbiter
// Directed and randomized transactions against a transaction-level model:
// expected grant order, latched fields, response cycle and data are derived
// from the arbitration rules and a fixed cycle schedule per transaction.
module tb_ysyx_22050039_mem_arbiter;

    localparam int XLEN = 64;
    localparam int TMO  = 16;

    logic            clk;
    logic            rst;
    logic            if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [XLEN-1:0] if_addr, if_rdata;
    logic            ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid, ls_rsp_err;
    logic [XLEN-1:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]      ls_wmask;
    logic            mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]      mem_wmask;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // model state
    bit              m_last_ls;
    logic [XLEN-1:0] m_if_rdata, m_ls_rdata;
    bit              m_if_err, m_ls_err;

    ysyx_22050039_mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata), .ls_rsp_err(ls_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_last_ls  = 1'b0;
        m_if_rdata = '0;
        m_ls_rdata = '0;
        m_if_err   = 1'b0;
        m_ls_err   = 1'b0;
    endtask

    task automatic chk_rsp(input bit if_pulse, input bit ls_pulse);
        chk1("if_rsp_valid", if_rsp_valid, if_pulse);
        chk1("ls_rsp_valid", ls_rsp_valid, ls_pulse);
        chk64("if_rdata", if_rdata, m_if_rdata);
        chk64("ls_rdata", ls_rdata, m_ls_rdata);
        chk1("if_rsp_err", if_rsp_err, m_if_err);
        chk1("ls_rsp_err", ls_rsp_err, m_ls_err);
    endtask

    // Issue one request (or a tie) and return the expected latched fields.
    task automatic issue(input bit want_if, input bit want_ls, input logic [63:0] ia,
                         input logic [63:0] la, input bit wen, input logic [63:0] wd,
                         input logic [7:0] wm, output bit win_ls,
                         output logic [63:0] e_addr, output logic [63:0] e_wdata,
                         output logic e_wen, output logic [7:0] e_wmask);
        win_ls       = want_ls && (!want_if || !m_last_ls);
        if_req_valid = want_if;  if_addr = ia;
        ls_req_valid = want_ls;  ls_addr = la;
        ls_wen = wen; ls_wdata = wd; ls_wmask = wm;
        #1;
        chk1("if_req_ready", if_req_ready, want_if && !win_ls);
        chk1("ls_req_ready", ls_req_ready, win_ls);
        e_addr  = win_ls ? la : ia;
        e_wdata = win_ls ? wd : 64'd0;
        e_wen   = win_ls && wen;
        e_wmask = win_ls ? wm : 8'd0;
        m_last_ls = win_ls;
        nxt();
        // both requesters keep asking with new values; nothing may be accepted
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        if_addr = r64(); ls_addr = r64(); ls_wdata = r64(); ls_wmask = 8'($urandom);
        ls_wen = 1'($urandom);
    endtask

    task automatic chk_busy(input logic exp_mem_valid, input logic [63:0] e_addr,
                            input logic [63:0] e_wdata, input logic e_wen,
                            input logic [7:0] e_wmask);
        #1;
        chk1("mem_req_valid", mem_req_valid, exp_mem_valid);
        chk64("mem_addr", mem_addr, e_addr);
        chk64("mem_wdata", mem_wdata, e_wdata);
        chk1("mem_wen", mem_wen, e_wen);
        chk64("mem_wmask", 64'(mem_wmask), 64'(e_wmask));
        chk1("if_req_ready_busy", if_req_ready, 1'b0);
        chk1("ls_req_ready_busy", ls_req_ready, 1'b0);
        chk1("if_rsp_valid_busy", if_rsp_valid, 1'b0);
        chk1("ls_rsp_valid_busy", ls_rsp_valid, 1'b0);
    endtask

    // Normal transaction: ready after d stall cycles, response r cycles into RESP.
    task automatic txn(input bit want_if, input bit want_ls, input logic [63:0] ia,
                       input logic [63:0] la, input bit wen, input logic [63:0] wd,
                       input logic [7:0] wm, input logic [63:0] rd, input int d, input int r);
        bit win_ls;
        logic [63:0] ea, ewd;
        logic ewen;
        logic [7:0] ewm;
        issue(want_if, want_ls, ia, la, wen, wd, wm, win_ls, ea, ewd, ewen, ewm);
        for (int i = 0; i <= d; i++) begin
            mem_req_ready = (i == d);
            mem_rsp_valid = 1'($urandom);   // stray responses in REQ are ignored
            mem_rdata     = r64();
            chk_busy(1'b1, ea, ewd, ewen, ewm);
            nxt();
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i <= r; i++) begin
            mem_rsp_valid = (i == r);
            mem_rdata     = (i == r) ? rd : r64();
            if (i == r) begin
                if_req_valid = 1'b0;
                ls_req_valid = 1'b0;
            end
            chk_busy(1'b0, ea, ewd, ewen, ewm);
            nxt();
        end
        mem_rsp_valid = 1'b0;
        if (win_ls) begin
            m_ls_rdata = ewen ? 64'd0 : rd;
            m_ls_err   = 1'b0;
        end else begin
            m_if_rdata = rd;
            m_if_err   = 1'b0;
        end
        chk_rsp(!win_ls, win_ls);
        chk1("mem_req_valid_done", mem_req_valid, 1'b0);
    endtask

    // Memory never answers; ready after d cycles (d >= TMO means never ready).
    task automatic txn_timeout(input bit want_if, input bit want_ls, input int d);
        bit win_ls;
        logic [63:0] ea, ewd;
        logic ewen;
        logic [7:0] ewm;
        issue(want_if, want_ls, r64(), r64(), 1'($urandom), r64(), 8'($urandom),
              win_ls, ea, ewd, ewen, ewm);
        for (int k = 0; k < TMO; k++) begin
            mem_req_ready = (k == d);
            mem_rsp_valid = 1'b0;
            if (k == TMO - 1) begin
                if_req_valid = 1'b0;
                ls_req_valid = 1'b0;
            end
            chk_busy(k <= d, ea, ewd, ewen, ewm);
            nxt();
        end
        mem_req_ready = 1'b0;
        if (win_ls) begin
            m_ls_rdata = '0; m_ls_err = 1'b1;
        end else begin
            m_if_rdata = '0; m_if_err = 1'b1;
        end
        chk_rsp(!win_ls, win_ls);
        chk1("mem_req_valid_tmo", mem_req_valid, 1'b0);
        // a late response while idle must produce nothing
        mem_rsp_valid = 1'b1;
        mem_rdata     = r64();
        nxt();
        mem_rsp_valid = 1'b0;
        chk_rsp(1'b0, 1'b0);
        chk1("mem_req_valid_late", mem_req_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        if_req_valid = 1'b0; if_addr = '0;
        ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        model_reset();
        nxt();
        nxt();
        // reset state, with requests pending: nothing may be granted
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        #1;
        chk1("reset_if_req_ready", if_req_ready, 1'b0);
        chk1("reset_ls_req_ready", ls_req_ready, 1'b0);
        chk1("reset_mem_req_valid", mem_req_valid, 1'b0);
        chk64("reset_mem_addr", mem_addr, 64'd0);
        chk1("reset_mem_wen", mem_wen, 1'b0);
        chk_rsp(1'b0, 1'b0);
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        nxt();
        rst = 1'b1;
        nxt();

        // IF only, immediate ready, response next cycle
        txn(1, 0, 64'h8000_0000, 64'd0, 0, 64'd0, 8'd0, 64'h0000_0013_0000_0297, 0, 0);
        // ties alternate, first tie after reset goes to LS
        for (int i = 0; i < 4; i++)
            txn(1, 1, r64(), r64(), 0, r64(), 8'($urandom), r64(), 0, 0);
        // LS write with exact fields
        txn(0, 1, r64(), 64'h8000_1000, 1, 64'hdead_beef, 8'h0f, r64(), 0, 0);
        // 5-cycle ready stall, then a slow response
        txn(0, 1, r64(), r64(), 0, r64(), 8'hff, r64(), 5, 3);
        // timeouts: LS never ready, IF accepted but never answered
        txn_timeout(0, 1, TMO + 4);
        txn_timeout(1, 0, 3);
        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit wi, wl;
            wi = 1'($urandom);
            wl = 1'($urandom);
            if (!wi && !wl) wi = 1'b1;
            txn(wi, wl, r64(), r64(), 1'($urandom), r64(), 8'($urandom), r64(),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
        end

        // reset in the middle of RESP: outputs clear at once, no response later
        begin
            bit win_ls;
            logic [63:0] ea, ewd;
            logic ewen;
            logic [7:0] ewm;
            issue(1, 0, r64(), 64'd0, 0, 64'd0, 8'd0, win_ls, ea, ewd, ewen, ewm);
            mem_req_ready = 1'b1;
            nxt();
            mem_req_ready = 1'b0;
            rst = 1'b0;
            model_reset();
            #1;
            chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
            chk64("rst_mem_addr", mem_addr, 64'd0);
            chk1("rst_if_req_ready", if_req_ready, 1'b0);
            chk1("rst_ls_req_ready", ls_req_ready, 1'b0);
            chk_rsp(1'b0, 1'b0);
            mem_rsp_valid = 1'b1;
            mem_rdata     = r64();
            nxt();
            rst = 1'b1;
            mem_rsp_valid = 1'b0;
            if_req_valid = 1'b0; ls_req_valid = 1'b0;
            nxt();
            chk_rsp(1'b0, 1'b0);
        end
        txn(1, 0, 64'h8000_0004, 64'd0, 0, 64'd0, 8'd0, r64(), 0, 0);
        txn(1, 1, r64(), r64(), 0, r64(), 8'hff, r64(), 1, 1);
        txn(1, 1, r64(), r64(), 0, r64(), 8'hff, r64(), 0, 2);

        nxt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
